// File: rtl/jk_seq_pkg.sv
// Shared opcodes, FSM state encoding and opcode classification helpers
// for the JK bank sequencer.
package jk_seq_pkg;

    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_CLEAR  = 3'd1;
    localparam logic [2:0] OP_SET    = 3'd2;
    localparam logic [2:0] OP_LOAD   = 3'd3;
    localparam logic [2:0] OP_TOGGLE = 3'd4;
    localparam logic [2:0] OP_UP     = 3'd5;
    localparam logic [2:0] OP_DOWN   = 3'd6;
    localparam logic [2:0] OP_RSVD   = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    // Ops that always take exactly one step, whatever cmd_count says.
    function automatic logic op_is_single(input logic [2:0] op);
        return (op == OP_CLEAR) || (op == OP_SET) || (op == OP_LOAD);
    endfunction

    function automatic logic op_is_multi(input logic [2:0] op);
        return (op == OP_TOGGLE) || (op == OP_UP) || (op == OP_DOWN);
    endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational J/K excitation for one step of a command, using the
// bank's present Q as feedback for the counting ops.
module jk_excite
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    logic [WIDTH-1:0] up_t_s;
    logic [WIDTH-1:0] dn_t_s;

    // Ripple toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
    always_comb begin : toggle_enables
        logic run_up;
        logic run_dn;
        run_up = 1'b1;
        run_dn = 1'b1;
        up_t_s = {WIDTH{1'b0}};
        dn_t_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            up_t_s[i] = run_up;
            dn_t_s[i] = run_dn;
            run_up    = run_up & q[i];
            run_dn    = run_dn & ~q[i];
        end
    end

    // Per-opcode excitation selection.
    always_comb begin
        j = {WIDTH{1'b0}};
        k = {WIDTH{1'b0}};
        case (op)
            OP_CLEAR: begin
                j = {WIDTH{1'b0}};
                k = {WIDTH{1'b1}};
            end
            OP_SET: begin
                j = {WIDTH{1'b1}};
                k = {WIDTH{1'b0}};
            end
            OP_LOAD: begin
                j = data;
                k = ~data;
            end
            OP_TOGGLE: begin
                j = {WIDTH{1'b1}};
                k = {WIDTH{1'b1}};
            end
            OP_UP: begin
                j = up_t_s;
                k = up_t_s;
            end
            OP_DOWN: begin
                j = dn_t_s;
                k = dn_t_s;
            end
            default: begin
                j = {WIDTH{1'b0}};
                k = {WIDTH{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command sequencer that turns a bank of external JK flip-flops into a
// loadable up/down counter by alternating DRIVE and SETTLE cycles.
module jk_bank_sequencer
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             err
);

    state_t           state_r;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] j_out_r;
    logic [WIDTH-1:0] k_out_r;
    logic             busy_r;
    logic             done_r;
    logic             wrap_r;
    logic             err_r;

    logic             accept_s;
    logic [CNT_W-1:0] steps_s;
    logic [2:0]       exc_op_s;
    logic [WIDTH-1:0] exc_data_s;
    logic [WIDTH-1:0] exc_j_s;
    logic [WIDTH-1:0] exc_k_s;

    assign cmd_ready = (state_r == S_IDLE) && !Rst;
    assign accept_s  = cmd_valid && cmd_ready;

    // Step count of the offered command; zero means it completes without touching the bank.
    always_comb begin
        if (op_is_single(cmd_op)) begin
            steps_s = CNT_W'(1'b1);
        end else if (op_is_multi(cmd_op)) begin
            steps_s = cmd_count;
        end else begin
            steps_s = {CNT_W{1'b0}};
        end
    end

    // J/K are registered, so the first step is computed from the command being accepted.
    always_comb begin
        if (state_r == S_IDLE) begin
            exc_op_s   = cmd_op;
            exc_data_s = cmd_data;
        end else begin
            exc_op_s   = op_r;
            exc_data_s = data_r;
        end
    end

    jk_excite #(
        .WIDTH (WIDTH)
    ) u_excite (
        .op   (exc_op_s),
        .data (exc_data_s),
        .q    (q_fb),
        .j    (exc_j_s),
        .k    (exc_k_s)
    );

    // Sequencer FSM, step counter, command latches and output pulse registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= S_IDLE;
            op_r    <= OP_NOP;
            data_r  <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            j_out_r <= {WIDTH{1'b0}};
            k_out_r <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            wrap_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            wrap_r  <= 1'b0;
            err_r   <= 1'b0;
            j_out_r <= {WIDTH{1'b0}};
            k_out_r <= {WIDTH{1'b0}};
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        op_r   <= cmd_op;
                        data_r <= cmd_data;
                        if (steps_s != {CNT_W{1'b0}}) begin
                            cnt_r   <= steps_s;
                            state_r <= S_DRIVE;
                            busy_r  <= 1'b1;
                            j_out_r <= exc_j_s;
                            k_out_r <= exc_k_s;
                        end else begin
                            done_r <= 1'b1;
                            err_r  <= (cmd_op == OP_RSVD);
                        end
                    end
                end
                S_DRIVE: begin
                    state_r <= S_SETTLE;
                    cnt_r   <= cnt_r - CNT_W'(1'b1);
                    wrap_r  <= ((op_r == OP_UP)   && (&q_fb)) ||
                               ((op_r == OP_DOWN) && !(|q_fb));
                end
                S_SETTLE: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        state_r <= S_DRIVE;
                        j_out_r <= exc_j_s;
                        k_out_r <= exc_k_s;
                    end else begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign j_out = j_out_r;
    assign k_out = k_out_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign wrap  = wrap_r;
    assign err   = err_r;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Self-checking bench: behavioural JK bank on Clk, directed vector table,
// hand-written corner sequences and randomized commands against a value-level model.
module tb_jk_bank_sequencer;

    localparam int W    = 4;
    localparam int CW   = 8;
    localparam int MASK = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [W-1:0]  cmd_data;
    logic [CW-1:0] cmd_count;
    logic [W-1:0]  bank_q;
    logic [W-1:0]  j_out;
    logic [W-1:0]  k_out;
    logic          busy;
    logic          done;
    logic          wrap;
    logic          err;
    logic          preset_en;
    logic [W-1:0]  preset_val;

    int passed = 0;
    int total  = 0;

    jk_bank_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .Clk       (clk),
        .Rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .q_fb      (bank_q),
        .j_out     (j_out),
        .k_out     (k_out),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Behavioural JK master-slave bank; preset only lets the bench set a start value.
    always @(posedge clk) begin
        if (preset_en) begin
            bank_q <= preset_val;
        end else begin
            for (int i = 0; i < W; i++) begin
                case ({j_out[i], k_out[i]})
                    2'b01:   bank_q[i] <= 1'b0;
                    2'b10:   bank_q[i] <= 1'b1;
                    2'b11:   bank_q[i] <= ~bank_q[i];
                    default: bank_q[i] <= bank_q[i];
                endcase
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Value-level reference: final bank value, done latency in edges, wrap count, err.
    task automatic model(input int v0, input int op, input int data, input int count,
                         output int vq, output int lat, output int wr, output int er);
        int n;
        vq = v0; wr = 0; er = (op == 7) ? 1 : 0;
        n  = (op >= 1 && op <= 3) ? 1 : ((op >= 4 && op <= 6) ? count : 0);
        case (op)
            1: vq = 0;
            2: vq = MASK;
            3: vq = data & MASK;
            4: for (int s = 0; s < count; s++) vq = (~vq) & MASK;
            5: for (int s = 0; s < count; s++) begin
                   if (vq == MASK) wr++;
                   vq = (vq + 1) % 16;
               end
            6: for (int s = 0; s < count; s++) begin
                   if (vq == 0) wr++;
                   vq = (vq + 15) % 16;
               end
            default: vq = v0;
        endcase
        lat = 2 * n;
    endtask

    task automatic preset(input int v);
        preset_en  = 1'b1;
        preset_val = W'(v);
        @(posedge clk);
        @(negedge clk);
        preset_en  = 1'b0;
    endtask

    // Called just after the accept edge; lat = edges from accept edge to start of the done cycle.
    task automatic wait_done(output int lat, output int wraps, output int wfirst,
                             output int errs, output int bad, output int fj, output int fk);
        lat = -1; wraps = 0; wfirst = -1; errs = 0; bad = 0; fj = -1; fk = -1;
        for (int c = 0; c <= 600; c++) begin
            @(negedge clk);
            if (!busy && ((j_out | k_out) != '0)) bad++;
            if (busy && cmd_ready) bad++;
            if (err && !done) bad++;
            if (c == 0 && busy) begin
                fj = int'(j_out);
                fk = int'(k_out);
            end
            if (wrap) begin
                if (wraps == 0) wfirst = c;
                wraps++;
            end
            if (done) begin
                lat  = c;
                errs = int'(err);
                break;
            end
            @(posedge clk);
        end
    endtask

    task automatic issue(input int op, input int data, input int count);
        cmd_valid = 1'b1;
        cmd_op    = 3'(op);
        cmd_data  = W'(data);
        cmd_count = CW'(count);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    typedef struct {
        int preset; int op; int data; int count;
        int eq; int elat; int ewr; int ewf; int eerr;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int lat, wr, wf, er, bad, fj, fk, frozen;
        int v, op, data, count, mq, mlat, mwr, mer;

        vecs[0]  = '{0,  3, 10, 0,   10, 2,   0,  -1, 0};
        vecs[1]  = '{14, 5, 0,  3,   1,  6,   1,  3,  0};
        vecs[2]  = '{0,  6, 0,  1,   15, 2,   1,  1,  0};
        vecs[3]  = '{6,  4, 0,  2,   6,  4,   0,  -1, 0};
        vecs[4]  = '{15, 1, 0,  9,   0,  2,   0,  -1, 0};
        vecs[5]  = '{0,  2, 0,  9,   15, 2,   0,  -1, 0};
        vecs[6]  = '{5,  7, 3,  4,   5,  0,   0,  -1, 1};
        vecs[7]  = '{9,  5, 0,  0,   9,  0,   0,  -1, 0};
        vecs[8]  = '{3,  0, 0,  4,   3,  0,   0,  -1, 0};
        vecs[9]  = '{0,  5, 0,  255, 15, 510, 15, 31, 0};
        vecs[10] = '{1,  6, 0,  3,   14, 6,   1,  3,  0};
        vecs[11] = '{6,  4, 0,  1,   9,  2,   0,  -1, 0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = '0; cmd_count = '0;
        preset_en = 1'b1; preset_val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", int'(cmd_ready), 0);
        chk("reset_busy",  int'(busy), 0);
        chk("reset_done",  int'(done), 0);
        chk("reset_jk",    int'(j_out | k_out), 0);
        chk("reset_pulses", int'({wrap, err}), 0);
        rst = 1'b0; preset_en = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Directed vector table.
        foreach (vecs[i]) begin
            preset(vecs[i].preset);
            issue(vecs[i].op, vecs[i].data, vecs[i].count);
            wait_done(lat, wr, wf, er, bad, fj, fk);
            chk($sformatf("vec%0d_lat", i),   lat,         vecs[i].elat);
            chk($sformatf("vec%0d_q", i),     int'(bank_q), vecs[i].eq);
            chk($sformatf("vec%0d_wraps", i), wr,          vecs[i].ewr);
            chk($sformatf("vec%0d_wfirst", i), wf,         vecs[i].ewf);
            chk($sformatf("vec%0d_err", i),   er,          vecs[i].eerr);
            chk($sformatf("vec%0d_proto", i), bad,         0);
            if (vecs[i].op == 3) begin
                chk($sformatf("vec%0d_drive_j", i), fj, vecs[i].data);
                chk($sformatf("vec%0d_drive_k", i), fk, (~vecs[i].data) & MASK);
            end
        end

        // Reset during the second DRIVE of COUNT_UP count=5: bank keeps the two steps taken.
        preset(0);
        issue(5, 0, 5);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_jk",    int'(j_out | k_out), 0);
        chk("abort_busy",  int'(busy), 0);
        chk("abort_done",  int'(done), 0);
        chk("abort_ready", int'(cmd_ready), 0);
        chk("abort_q",     int'(bank_q), 2);
        frozen = int'(bank_q);
        @(posedge clk);
        @(negedge clk);
        chk("abort_frozen", int'(bank_q), 2);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_ready_after", int'(cmd_ready), 1);
        chk("abort_frozen_after", int'(bank_q), frozen);

        // cmd_valid held while busy: the LOAD behind COUNT_UP waits for the done cycle.
        preset(0);
        cmd_valid = 1'b1; cmd_op = 3'd5; cmd_data = '0; cmd_count = 8'd2;
        @(posedge clk);
        #1 cmd_op = 3'd3; cmd_data = 4'b0101; cmd_count = 8'd0;
        wait_done(lat, wr, wf, er, bad, fj, fk);
        chk("held_first_lat", lat, 4);
        chk("held_first_q", int'(bank_q), 2);
        chk("held_first_proto", bad, 0);
        chk("held_ready_on_done", int'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        wait_done(lat, wr, wf, er, bad, fj, fk);
        chk("held_second_lat", lat, 2);
        chk("held_second_q", int'(bank_q), 5);

        // Randomized commands, sometimes back-to-back from the previous result.
        v = int'(bank_q);
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                v = int'($urandom_range(0, MASK));
                preset(v);
            end
            op    = int'($urandom_range(0, 7));
            data  = int'($urandom_range(0, MASK));
            count = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
            model(v, op, data, count, mq, mlat, mwr, mer);
            issue(op, data, count);
            wait_done(lat, wr, wf, er, bad, fj, fk);
            chk($sformatf("rnd%0d_op%0d_lat", it, op),   lat, mlat);
            chk($sformatf("rnd%0d_op%0d_q", it, op),     int'(bank_q), mq);
            chk($sformatf("rnd%0d_op%0d_wraps", it, op), wr, mwr);
            chk($sformatf("rnd%0d_op%0d_err", it, op),   er, mer);
            chk($sformatf("rnd%0d_op%0d_proto", it, op), bad, 0);
            v = mq;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
